// File: rtl/id_pkg.sv
// id_pkg: shared state encoding and counter widths for the serialization controller
package id_pkg;
  typedef enum logic [2:0] {IDLE, DRAIN, FLUSH, NOTIFY, RELEASE} state_t;
  localparam int CNT_W = 3;
  localparam int TO_W = 10;
endpackage

// File: rtl/id_serial_pick.sv
// id_serial_pick: lowest-set-bit priority encoder returning index and found flag
module id_serial_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  output logic [1:0]   idx,
  output logic         found
);
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = 2'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/id_serialize_ctrl.sv
// id_serialize_ctrl: drains, flushes and replays around serializing decode lanes
module id_serialize_ctrl
  import id_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DRAIN_CYCLES = 3,
  parameter int FLUSH_TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [LANES-1:0] instr_valid,
  input  logic [LANES-1:0] is_serial,
  input  logic [LANES-1:0] notify_sim,
  input  logic             stall_in,
  input  logic             flush_finished,
  output logic [LANES-1:0] issue_mask,
  output logic             bubble,
  output logic             flush,
  output logic             SYS,
  output logic             WANT_FREEZE,
  output logic             replay_req,
  output logic [1:0]       replay_lane,
  output logic [2:0]       sys_count,
  output logic             flush_timeout_err
);
  state_t st;
  logic [CNT_W-1:0] cnt;
  logic [TO_W-1:0] tcnt;
  logic [1:0] idx, k;
  logic found, note, rep, err;
  logic [LANES-1:0] below, hi, ns_sh;
  id_serial_pick #(.N(LANES)) u_pick (
    .req  (instr_valid & is_serial),
    .idx  (idx),
    .found(found)
  );
  always_comb begin
    below = instr_valid & ((LANES'(1) << idx) - LANES'(1));
    hi = (instr_valid >> idx) >> 1;
    ns_sh = notify_sim >> idx;
    // IDLE issue/freeze follow the live bundle; every other state is decoded from st
    issue_mask = st == IDLE ? ((RESET || stall_in) ? '0 : found ? below : instr_valid)
               : st == NOTIFY ? LANES'(1) << k : '0;
    WANT_FREEZE = st == IDLE ? (!RESET && (stall_in || found)) : st != RELEASE;
    bubble = st == DRAIN || st == FLUSH || st == RELEASE;
    flush = st == FLUSH;
    SYS = st == NOTIFY && note;
    replay_req = st == NOTIFY && rep;
    replay_lane = replay_req ? k : 2'd0;
    sys_count = st == DRAIN ? 3'(cnt) : 3'd0;
    flush_timeout_err = err;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st <= IDLE;
      cnt <= '0;
      tcnt <= '0;
      k <= '0;
      note <= 1'b0;
      rep <= 1'b0;
      err <= 1'b0;
    end else begin
      unique case (st)
        IDLE: if (!stall_in && found) begin
          st <= DRAIN;
          k <= idx;
          note <= ns_sh[0];
          rep <= |hi;
          cnt <= CNT_W'(DRAIN_CYCLES);
        end
        DRAIN: if (!stall_in) begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            st <= FLUSH;
            tcnt <= '0;
          end
        end
        FLUSH: begin
          tcnt <= tcnt + TO_W'(1);
          // an ack arriving on the last allowed cycle still counts as a clean exit
          if (flush_finished || tcnt == TO_W'(FLUSH_TIMEOUT - 1)) begin
            st <= NOTIFY;
            err <= err | !flush_finished;
          end
        end
        NOTIFY: st <= RELEASE;
        RELEASE: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_id_serialize_ctrl.sv
// tb_id_serialize_ctrl: directed and random stimulus against a sequence-position model
module tb_id_serialize_ctrl;
  localparam int L = 2;
  localparam int D = 3;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst;
  logic [L-1:0] iv, is_s, ns;
  logic stl, ff;
  logic [L-1:0] issue_mask;
  logic bubble, flush, SYS, WANT_FREEZE, replay_req, flush_timeout_err;
  logic [1:0] replay_lane;
  logic [2:0] sys_count;
  int checks = 0;
  int failures = 0;
  bit busy = 0;
  int pos = 0, mk = 0, fwait = 0;
  bit mnote = 0, mrep = 0, merr = 0;
  int lat;

  id_serialize_ctrl #(.LANES(L), .DRAIN_CYCLES(D), .FLUSH_TIMEOUT(TO)) dut (
    .CLK(clk), .RESET(rst), .instr_valid(iv), .is_serial(is_s), .notify_sim(ns),
    .stall_in(stl), .flush_finished(ff), .issue_mask(issue_mask), .bubble(bubble),
    .flush(flush), .SYS(SYS), .WANT_FREEZE(WANT_FREEZE), .replay_req(replay_req),
    .replay_lane(replay_lane), .sys_count(sys_count), .flush_timeout_err(flush_timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // pos counts progress since detection: 1..D drain, D+1 flush, D+2 notify, D+3 release
  task automatic cyc(input bit r, input logic [L-1:0] v, input logic [L-1:0] s,
                     input logic [L-1:0] n, input bit st_in, input bit f);
    int e_mask, e_wf, e_bub, e_fl, e_sys, e_rr, e_rl, e_sc, kk;
    @(negedge clk);
    rst = r; iv = v; is_s = s; ns = n; stl = st_in; ff = f;
    #1;
    e_mask = 0; e_wf = 0; e_bub = 0; e_fl = 0; e_sys = 0; e_rr = 0; e_rl = 0; e_sc = 0; kk = -1;
    if (!busy) begin
      for (int i = L - 1; i >= 0; i--) if (v[i] && s[i]) kk = i;
      if (!r && !st_in) e_mask = kk < 0 ? int'(v) : int'(v) & ((1 << kk) - 1);
      e_wf = int'(!r && (st_in || kk >= 0));
    end else if (pos <= D) begin
      e_bub = 1; e_wf = 1; e_sc = D - pos + 1;
    end else if (pos == D + 1) begin
      e_fl = 1; e_bub = 1; e_wf = 1;
    end else if (pos == D + 2) begin
      e_mask = 1 << mk; e_sys = int'(mnote); e_rr = int'(mrep); e_rl = mrep ? mk : 0; e_wf = 1;
    end else e_bub = 1;
    chk("issue_mask", int'(issue_mask), e_mask);
    chk("want_freeze", int'(WANT_FREEZE), e_wf);
    chk("bubble", int'(bubble), e_bub);
    chk("flush", int'(flush), e_fl);
    chk("sys", int'(SYS), e_sys);
    chk("replay_req", int'(replay_req), e_rr);
    chk("replay_lane", int'(replay_lane), e_rl);
    chk("sys_count", int'(sys_count), e_sc);
    chk("timeout_err", int'(flush_timeout_err), int'(merr));
    if (r) begin
      busy = 0; pos = 0; merr = 0;
    end else if (!busy) begin
      if (!st_in && kk >= 0) begin
        busy = 1; pos = 1; mk = kk; mnote = n[kk]; mrep = (v >> (kk + 1)) != 0;
      end
    end else if (pos <= D) begin
      if (!st_in) begin pos++; fwait = 0; end
    end else if (pos == D + 1) begin
      fwait++;
      if (f || fwait == TO) begin
        if (!f) merr = 1;
        pos++;
      end
    end else if (pos == D + 2) pos++;
    else busy = 0;
  endtask

  initial begin
    rst = 1; iv = '0; is_s = '0; ns = '0; stl = 0; ff = 0;
    repeat (2) @(posedge clk);
    cyc(1, 2'b11, 2'b01, 2'b01, 0, 0);
    cyc(0, 2'b00, 2'b00, 2'b00, 0, 0);
    // lane0 syscall, immediate ack, also measures detection-to-idle latency
    cyc(0, 2'b01, 2'b01, 2'b01, 0, 1);
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 2'b00, 2'b00, 2'b00, 0, 1);
      lat++;
      if (bubble && !WANT_FREEZE) break;
    end
    chk("latency", lat, D + 4);
    cyc(0, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc(0, 2'b11, 2'b10, 2'b10, 0, 1);
    repeat (7) cyc(0, 2'b00, 2'b00, 2'b00, 0, 1);
    cyc(0, 2'b11, 2'b01, 2'b00, 0, 1);
    repeat (7) cyc(0, 2'b00, 2'b00, 2'b00, 0, 1);
    cyc(0, 2'b01, 2'b01, 2'b01, 0, 1);
    cyc(0, 2'b00, 2'b00, 2'b00, 0, 1);
    cyc(0, 2'b00, 2'b00, 2'b00, 1, 1);
    cyc(0, 2'b00, 2'b00, 2'b00, 1, 1);
    repeat (6) cyc(0, 2'b00, 2'b00, 2'b00, 0, 1);
    // flush never acknowledged: timeout path and sticky error
    cyc(0, 2'b11, 2'b11, 2'b11, 0, 0);
    repeat (10) cyc(0, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc(0, 2'b11, 2'b11, 2'b01, 0, 0);
    repeat (4) cyc(0, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc(1, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc(0, 2'b00, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 199) == 0, L'($urandom), L'($urandom), L'($urandom),
          $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_serialize_ctrl.md
ID_SERIALIZE_CTRL -- requirements
Module: id_serialize_ctrl

Interface
REQ-001 LANES, default 2, number of decode lanes (1..4); lane 0 is oldest.
REQ-002 DRAIN_CYCLES, default 3, bubble cycles before flush (1..7).
REQ-003 FLUSH_TIMEOUT, default 255, max FLUSH-state cycles before forced exit (1..1023).
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 instr_valid  in  LANES  lane holds a valid decoded instruction.
REQ-007 is_serial  in  LANES  lane decodes as serializing (syscall, LL, SC).
REQ-008 notify_sim  in  LANES  serializing lane must raise SYS (syscall only; LL/SC low).
REQ-009 stall_in  in  1  cache miss or fetch not-hit; holds the sequencer.
REQ-010 flush_finished  in  1  MEM-stage flush-complete acknowledge.
REQ-011 issue_mask  out  LANES  lanes allowed to pass to EXE this cycle.
REQ-012 bubble  out  1  EXE receives a NOP this cycle.
REQ-013 flush  out  1  cache-flush request.
REQ-014 SYS  out  1  one-cycle simulator system-call pulse.
REQ-015 WANT_FREEZE  out  1  fetch must hold PC.
REQ-016 replay_req  out  1  one-cycle pulse: fetch re-presents lanes younger than serial lane.
REQ-017 replay_lane  out  2  index of serial lane, valid with replay_req.
REQ-018 sys_count  out  3  remaining drain cycles (0 outside DRAIN).
REQ-019 flush_timeout_err  out  1  sticky: a flush timed out.

Function
REQ-020 States: IDLE, DRAIN, FLUSH, NOTIFY, RELEASE; outputs except issue_mask/WANT_FREEZE in IDLE are Moore-decoded from registered state.
REQ-021 IDLE, stall_in=1: issue_mask=0, WANT_FREEZE=1, state held.
REQ-022 IDLE, no valid serial lane, stall_in=0: issue_mask=instr_valid, WANT_FREEZE=0.
REQ-023 IDLE, k = lowest lane with instr_valid&is_serial, stall_in=0: issue_mask = valid lanes below k; WANT_FREEZE=1; latch k and notify_sim[k]; drain counter := DRAIN_CYCLES; next DRAIN.
REQ-024 DRAIN: bubble=1, issue_mask=0, WANT_FREEZE=1; counter decrements only when stall_in=0; counter 1->0 transitions to FLUSH.
REQ-025 FLUSH: flush=1, bubble=1, WANT_FREEZE=1; flush_finished sampled only here; on flush_finished=1 next NOTIFY.
REQ-026 FLUSH timeout counter counts FLUSH cycles; at FLUSH_TIMEOUT without ack set flush_timeout_err and go NOTIFY.
REQ-027 NOTIFY: issue_mask=one-hot k (serial instruction propagates to MEM); SYS=latched notify_sim; replay_req=1 iff any lane above k was valid at detection; WANT_FREEZE=1; next RELEASE.
REQ-028 RELEASE: WANT_FREEZE=0, issue_mask=0, bubble=1 for exactly one cycle; next IDLE.
REQ-029 stall_in is ignored in FLUSH, NOTIFY, RELEASE; flush_finished outside FLUSH is ignored.
REQ-030 Back-to-back serial instructions: each completes full sequence; none skipped or merged.
REQ-031 Two serial lanes in one bundle: only lowest handled; higher re-presented via replay.
REQ-032 LANES=1: replay_req constant 0, replay_lane constant 0.
REQ-033 Minimum serialization latency (no stalls, immediate ack) = DRAIN_CYCLES+4 cycles detection to IDLE.

Reset
REQ-034 RESET=1 at any edge, including mid-sequence: state IDLE, all counters 0, all outputs 0, flush_timeout_err cleared.
REQ-035 While RESET=1, combinational IDLE outputs are forced to 0 (issue_mask=0, WANT_FREEZE=0).

Structure
REQ-036 State encoding enum and counter widths in shared package id_pkg.
REQ-037 One sub-module: id_serial_pick (lowest-set-bit priority encoder, outputs index and found).

Verification
REQ-038 LANES=2, DRAIN=3; lane0 syscall, notify=1, ack immediate -> bubble 3 cycles, flush 1 cycle, SYS pulse 1, replay_req=0 if lane1 invalid.
REQ-039 Lane0 add, lane1 syscall, no stall -> issue_mask=01 at detection, NOTIFY issue_mask=10, replay_req=0.
REQ-040 Lane0 LL (notify=0), lane1 valid -> SYS stays 0, replay_req=1, replay_lane=0.
REQ-041 stall_in=1 two cycles mid-DRAIN -> sys_count holds, DRAIN lasts 5 cycles total.
REQ-042 FLUSH_TIMEOUT=4, flush_finished never -> flush high 4 cycles, flush_timeout_err=1 and stays 1 until RESET.
REQ-043 RESET asserted in FLUSH -> next cycle flush=0, state IDLE, all outputs 0.
